// File: rtl/sound_pkg.sv
// Shared event codes and sequencer state encoding for the sound producer path.
package sound_pkg;

  typedef logic [1:0] ev_code_t;

  // Codes line up with the sound controller's own state encoding.
  localparam ev_code_t EV_NONE   = 2'd0;
  localparam ev_code_t EV_GOAL   = 2'd1;
  localparam ev_code_t EV_PADDLE = 2'd2;
  localparam ev_code_t EV_WALL   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } seq_state_t;

  // rise = {goal, paddle, wall}; goal wins, then paddle, then wall.
  function automatic ev_code_t encode_event(input logic [2:0] rise);
    if (rise[2])      return EV_GOAL;
    else if (rise[1]) return EV_PADDLE;
    else if (rise[0]) return EV_WALL;
    else              return EV_NONE;
  endfunction

endpackage

// File: rtl/sound_event_fifo.sv
// Small DEPTH x 2-bit event FIFO; a push into a full FIFO is taken only when a pop happens in the same cycle.
module sound_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [1:0]               din,
  output logic [1:0]               dout,
  output logic [1:0]               tail_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] tail_ptr;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign tail_ptr  = wr_ptr_reg - AW'(1);
  assign dout      = mem_reg[rd_ptr_reg];
  assign tail_data = mem_reg[tail_ptr];
  assign count     = count_reg;

  // Pointers are AW bits wide on a power-of-two depth, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sound_event_sequencer.sv
// Turns level collision flags into spaced one-cycle goal/paddle/wall strobes for the sound controller.
// Build option SOUND_COALESCE_EN: drop an event equal to the newest queued entry.
module sound_event_sequencer
  import sound_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 4,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hit_goal,
  input  logic                   hit_paddle,
  input  logic                   hit_wall,
  output logic                   goal,
  output logic                   paddle,
  output logic                   wall,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES + GAP_CYCLES - 1);

`ifdef SOUND_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic       goal_d_reg, paddle_d_reg, wall_d_reg;
  logic [2:0] rise;
  logic       multi_hit;
  ev_code_t   ev_next;
  ev_code_t   ev_reg;
  ev_code_t   head_code;
  ev_code_t   tail_code;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty, drop;

  seq_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             goal_reg, paddle_reg, wall_reg, busy_reg, overflow_reg;

  assign rise      = {hit_goal & ~goal_d_reg, hit_paddle & ~paddle_d_reg, hit_wall & ~wall_d_reg};
  assign multi_hit = (rise[2] & rise[1]) | (rise[2] & rise[0]) | (rise[1] & rise[0]);
  assign ev_next   = encode_event(rise);

  assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;
  assign fifo_push = (ev_reg != EV_NONE) && !(COALESCE && !fifo_empty && (tail_code == ev_reg));
  assign drop      = fifo_push && fifo_full && !fifo_pop;

  sound_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (ev_reg),
    .dout      (head_code),
    .tail_data (tail_code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      goal_d_reg   <= 1'b0;
      paddle_d_reg <= 1'b0;
      wall_d_reg   <= 1'b0;
      ev_reg       <= EV_NONE;
      overflow_reg <= 1'b0;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      goal_reg     <= 1'b0;
      paddle_reg   <= 1'b0;
      wall_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      goal_d_reg   <= hit_goal;
      paddle_d_reg <= hit_paddle;
      wall_d_reg   <= hit_wall;
      ev_reg       <= ev_next;
      overflow_reg <= overflow_reg | multi_hit | drop;
      case (state_reg)
        IDLE: begin
          if (fifo_pop) begin
            state_reg  <= ISSUE;
            busy_reg   <= 1'b1;
            goal_reg   <= (head_code == EV_GOAL);
            paddle_reg <= (head_code == EV_PADDLE);
            wall_reg   <= (head_code == EV_WALL);
          end
        end
        ISSUE: begin
          goal_reg   <= 1'b0;
          paddle_reg <= 1'b0;
          wall_reg   <= 1'b0;
          cnt_reg    <= CNT_LOAD;
          state_reg  <= HOLD;
        end
        HOLD: begin
          // The extra IDLE cycle after cnt hits 0 gives the sound FSM time to settle.
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign goal     = goal_reg;
  assign paddle   = paddle_reg;
  assign wall     = wall_reg;
  assign busy     = busy_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Randomized and directed bench for sound_event_sequencer against a queue/timeline reference model.
module tb_sound_event_sequencer;

  localparam int H = 20;
  localparam int G = 4;
  localparam int D = 4;

`ifdef SOUND_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hit_goal = 1'b0, hit_paddle = 1'b0, hit_wall = 1'b0;
  logic       goal, paddle, wall, busy, overflow;
  logic [2:0] pending;

  int checks = 0;
  int failures = 0;

  sound_event_sequencer #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .DEPTH(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hit_goal   (hit_goal),
    .hit_paddle (hit_paddle),
    .hit_wall   (hit_wall),
    .goal       (goal),
    .paddle     (paddle),
    .wall       (wall),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of codes plus the edge times at which the player is free again.
  int         edge_n = 0;
  int         free_edge = 0;
  int         busy_last = -1;
  logic [1:0] q[$];
  logic [1:0] stage = 2'd0;
  logic [2:0] prev = 3'd0;
  bit         ov_m = 1'b0;
  logic [1:0] exp_strobe = 2'd0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_edge(input logic g, input logic p, input logic w, input logic r);
    bit         do_pop;
    bit         accept;
    logic [2:0] rise;
    logic [1:0] popped;
    edge_n++;
    if (!r) begin
      q.delete();
      stage = 2'd0;
      prev = 3'd0;
      ov_m = 1'b0;
      exp_strobe = 2'd0;
      busy_last = -1;
      free_edge = edge_n + 1;
      return;
    end
    do_pop = (edge_n >= free_edge) && (q.size() > 0);
    accept = 1'b0;
    popped = 2'd0;
    if (stage != 2'd0) begin
      if (COALESCE && q.size() > 0 && q[$] == stage) accept = 1'b0;
      else if (q.size() < D || do_pop) accept = 1'b1;
      else ov_m = 1'b1;
    end
    if (do_pop) popped = q.pop_front();
    if (accept) q.push_back(stage);
    if (do_pop) begin
      busy_last = edge_n + H + G;
      free_edge = edge_n + H + G + 2;
    end
    exp_strobe = popped;
    rise = {g, p, w} & ~prev;
    if ($countones(rise) > 1) ov_m = 1'b1;
    stage = rise[2] ? 2'd1 : rise[1] ? 2'd2 : rise[0] ? 2'd3 : 2'd0;
    prev = {g, p, w};
  endtask

  task automatic step(input logic g, input logic p, input logic w, input logic r);
    hit_goal = g;
    hit_paddle = p;
    hit_wall = w;
    reset_n = r;
    model_edge(g, p, w, r);
    @(posedge clk);
    @(negedge clk);
    check_eq("goal", int'(goal), int'(exp_strobe == 2'd1));
    check_eq("paddle", int'(paddle), int'(exp_strobe == 2'd2));
    check_eq("wall", int'(wall), int'(exp_strobe == 2'd3));
    check_eq("busy", int'(busy), int'(edge_n <= busy_last));
    check_eq("pending", int'(pending), q.size());
    check_eq("overflow", int'(overflow), int'(ov_m));
    if (goal | paddle | wall)
      $display("edge %0d strobe g=%0b p=%0b w=%0b pending=%0d overflow=%0b",
               edge_n, goal, paddle, wall, pending, overflow);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0] h;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    // Single paddle hit, held high for a while.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(40);
    // Three wall edges two cycles apart.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    idle(90);
    // Goal and wall together.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    idle(35);
    // Six pulses while a note holds: queue saturates.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(5);
    for (int i = 0; i < 6; i++) begin
      step(i % 3 == 0, i % 3 == 1, i % 3 == 2, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    idle(20);
    // Keep pushing around the IDLE dequeue while full.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    // Reset in the middle of a hold with entries queued.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(60);
    // Reset released with a level already high.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    // Random traffic with occasional resets.
    h = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 9) == 0) h[b] = ~h[b];
      step(h[2], h[1], h[0], $urandom_range(0, 499) != 0);
    end
    idle(150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
